fpu_req_arbiter: RTL and testbench
==================================

// Module: fpu_req_arbiter
// PURPOSE
//   Shares one FPU add/sub unit among NUM_REQ requesters. Round-robin arbitration, one
//   operation in flight at a time. Sequences the FPU calc pulse and captures data_out/state_out.
//   Returns result and State_e status to the granted requester. Sits between client blocks
//   and the single FPU instance.
// PARAMETERS
//   NUM_REQ  4   number of requesters (2..16)
//   CNT_W    16  width of exception counter (FPU_ARB_EXC_CNT_EN only)
// PORTS
//   clock        in   1           system clock, all logic on posedge
//   reset        in   1           synchronous, active-low
//   req_valid    in   NUM_REQ     per-requester request
//   req_ready    out  NUM_REQ     one-hot accept; handshake = valid & ready
//   req_op_a     in   NUM_REQ*32  packed operand A, slice i belongs to requester i
//   req_op_b     in   NUM_REQ*32  packed operand B
//   resp_valid   out  NUM_REQ     one-hot, 1-cycle pulse for the requester whose op completed
//   resp_data    out  32          result, valid with resp_valid
//   resp_state   out  State_e     EXACT/INEXACT/OVERFLOW/UNDERFLOW, valid with resp_valid
//   busy         out  1           high in ISSUE or WAIT
//   fpu_op_a     out  32          to FPU op_A_in
//   fpu_op_b     out  32          to FPU op_B_in
//   fpu_calc     out  1           to FPU calc
//   fpu_data     in   32          from FPU data_out
//   fpu_state    in   State_e     from FPU state_out
//   exc_count    out  CNT_W       OVERFLOW+UNDERFLOW responses seen (0 without macro)
// BEHAVIOUR
//   Reset (reset==0 at posedge):
//     - state=IDLE; req_ready=0; resp_valid=0; resp_data=0; resp_state=EXACT.
//     - fpu_calc=0; fpu_op_a/b=0; rr pointer=NUM_REQ-1, so requester 0 wins first.
//     - exc_count=0.
//     - The FPU shares the same reset.
//   FSM IDLE -> ISSUE -> WAIT -> IDLE, no other transitions:
//     - IDLE: req_ready is combinational, one-hot for the highest-priority valid requester.
//       Priority starts at ptr+1, wrapping. req_ready=0 if no valid.
//       On handshake: latch ops and grant id, ptr<=id, go ISSUE.
//     - ISSUE: fpu_calc=1 for exactly this cycle, fpu_op_a/b = latched ops. Go WAIT.
//     - WAIT: fpu_data/fpu_state hold the result. At this edge:
//       resp_data<=fpu_data, resp_state<=fpu_state, resp_valid[id]<=1. Go IDLE.
//   Timing:
//     - Latency: handshake edge T -> resp_valid high in cycle T+3 (pulse, one cycle).
//     - Throughput: one op per 3 cycles.
//     - A new handshake is allowed in the same IDLE cycle that resp_valid is high.
//       This includes the same requester.
//   Outputs and requester obligations:
//     - fpu_op_a/b are registered and held after ISSUE; fpu_calc=0 outside ISSUE.
//     - req_ready=0 in ISSUE/WAIT. A requester holds valid and operands stable until ready.
//       Dropping valid before ready is legal; the request is withdrawn.
//   Edge cases:
//     - Reset mid-operation (ISSUE/WAIT): op aborted, no resp_valid, all outputs at reset values.
//     - Single requester continuously valid: served every 3 cycles, never starved.
//     - All valid: strict rotation.
// CONFIGURATION
//   FPU_ARB_EXC_CNT_EN defined:
//     - In WAIT, if fpu_state is OVERFLOW or UNDERFLOW, exc_count increments.
//     - Saturates at 2^CNT_W-1; cleared only by reset.
//   FPU_ARB_EXC_CNT_EN undefined: exc_count tied to 0, no counter flops.
// STRUCTURE
//   - State_e reused from the existing States package.
//   - Add to that package: ArbState_e {ARB_IDLE, ARB_ISSUE, ARB_WAIT}; localparam FPU_W=32.
//   - Sub-module rr_picker: combinational round-robin (req vector, ptr) -> one-hot grant + id.
//     Parameterised by NUM_REQ.
// TESTING
//   Operand encodings: 1.0=0x3E000000, 2.0=0x40000000, max-exp 0x7E000000.
//   1. req0 1.0+1.0 after reset
//      -> req_ready[0] same cycle; fpu_calc 1 cycle later;
//         resp_valid=0001, resp_data=0x40000000, EXACT at T+3.
//   2. req0..3 all valid at once, held
//      -> grants 0,1,2,3,0 at 3-cycle spacing; resp_valid one-hot in the same order.
//   3. req0 held valid permanently, req2 valid -> grants alternate 0,2,0,2; no starvation.
//   4. req1 0x7E000000+0x7E000000
//      -> resp_data 0x7E000000, OVERFLOW;
//         exc_count=1 with FPU_ARB_EXC_CNT_EN, 0 without.
//   5. reset low during ISSUE
//      -> no resp_valid ever for that op; next request from req3 with req0 valid grants req0 first.
//   6. req2 re-asserts in the cycle its resp_valid pulses
//      -> handshake accepted that cycle; second resp_valid exactly 3 cycles later.

Source files
------------

// File: rtl/fpu_req_arbiter_pkg.sv
// Shared types for the FPU request arbiter: FPU status encoding, arbiter FSM states, data width.
package fpu_req_arbiter_pkg;

  localparam int unsigned FPU_W = 32;

  typedef enum logic [1:0] {EXACT, INEXACT, OVERFLOW, UNDERFLOW} State_e;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT} ArbState_e;

  function automatic logic is_exc(State_e s);
    return (s == OVERFLOW) || (s == UNDERFLOW);
  endfunction

endpackage

// File: rtl/fpu_req_arbiter_rr_picker.sv
// Combinational round-robin picker: the first set request after ptr_i (wrapping) wins.
module fpu_req_arbiter_rr_picker #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdW    = 2
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdW-1:0]    ptr_i,
  output logic [NumReq-1:0] gnt_o,
  output logic [IdW-1:0]    id_o,
  output logic              any_o
);

  always_comb begin
    int unsigned idx;
    gnt_o = '0;
    id_o  = '0;
    any_o = 1'b0;
    // Walk from ptr+1 up to ptr itself so the last winner has lowest priority.
    for (int unsigned i = 1; i <= NumReq; i++) begin
      idx = (int'(ptr_i) + i) % NumReq;
      if (!any_o && req_i[idx]) begin
        any_o      = 1'b1;
        gnt_o[idx] = 1'b1;
        id_o       = IdW'(idx);
      end
    end
  end

endmodule

// File: rtl/fpu_req_arbiter.sv
// Round-robin sharing of one FPU add/sub unit, one op in flight (IDLE -> ISSUE -> WAIT).
// Optional exception counter enabled by defining FPU_ARB_EXC_CNT_EN.
module fpu_req_arbiter
  import fpu_req_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [NUM_REQ*FPU_W-1:0] req_op_a_i,
  input  logic [NUM_REQ*FPU_W-1:0] req_op_b_i,
  output logic [NUM_REQ-1:0]       resp_valid_o,
  output logic [FPU_W-1:0]         resp_data_o,
  output State_e                   resp_state_o,
  output logic                     busy_o,
  output logic [FPU_W-1:0]         fpu_op_a_o,
  output logic [FPU_W-1:0]         fpu_op_b_o,
  output logic                     fpu_calc_o,
  input  logic [FPU_W-1:0]         fpu_data_i,
  input  State_e                   fpu_state_i,
  output logic [CNT_W-1:0]         exc_count_o
);

  localparam int unsigned IdW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  ArbState_e state_q, state_d;

  logic [IdW-1:0]     ptr_q, id_q, pick_id;
  logic [NUM_REQ-1:0] pick_gnt, resp_valid_q;
  logic               pick_any, handshake;
  logic [FPU_W-1:0]   op_a_q, op_b_q, resp_data_q;
  State_e             resp_state_q;

  fpu_req_arbiter_rr_picker #(
    .NumReq (NUM_REQ),
    .IdW    (IdW)
  ) u_rr_picker (
    .req_i  (req_valid_i),
    .ptr_i  (ptr_q),
    .gnt_o  (pick_gnt),
    .id_o   (pick_id),
    .any_o  (pick_any)
  );

  assign handshake = (state_q == ARB_IDLE) && pick_any;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= ARB_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE:  if (pick_any) state_d = ARB_ISSUE;
      ARB_ISSUE: state_d = ARB_WAIT;
      ARB_WAIT:  state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = (state_q == ARB_IDLE) ? pick_gnt : '0;
    fpu_calc_o  = (state_q == ARB_ISSUE);
    busy_o      = (state_q != ARB_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ptr_q        <= IdW'(NUM_REQ - 1);
      id_q         <= '0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      resp_state_q <= EXACT;
    end else begin
      resp_valid_q <= '0;
      if (handshake) begin
        op_a_q <= req_op_a_i[pick_id*FPU_W +: FPU_W];
        op_b_q <= req_op_b_i[pick_id*FPU_W +: FPU_W];
        id_q   <= pick_id;
        ptr_q  <= pick_id;
      end
      // The FPU result is stable throughout WAIT; capture it as WAIT ends.
      if (state_q == ARB_WAIT) begin
        resp_data_q  <= fpu_data_i;
        resp_state_q <= fpu_state_i;
        resp_valid_q <= NUM_REQ'(1) << id_q;
      end
    end
  end

  assign fpu_op_a_o   = op_a_q;
  assign fpu_op_b_o   = op_b_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_data_o  = resp_data_q;
  assign resp_state_o = resp_state_q;

`ifdef FPU_ARB_EXC_CNT_EN
  logic [CNT_W-1:0] exc_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      exc_cnt_q <= '0;
    end else if (state_q == ARB_WAIT && is_exc(fpu_state_i) && exc_cnt_q != '1) begin
      exc_cnt_q <= exc_cnt_q + CNT_W'(1);
    end
  end

  assign exc_count_o = exc_cnt_q;
`else
  assign exc_count_o = '0;
`endif

endmodule

// File: tb/tb_fpu_req_arbiter.sv
// Directed self-checking bench for fpu_req_arbiter with a small registered FPU model.
module tb_fpu_req_arbiter;
  import fpu_req_arbiter_pkg::*;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned CNT_W   = 16;
  localparam logic [31:0] ONE     = 32'h3E00_0000;
  localparam logic [31:0] TWO     = 32'h4000_0000;
  localparam logic [31:0] MAXE    = 32'h7E00_0000;

`ifdef FPU_ARB_EXC_CNT_EN
  localparam logic [31:0] EXP_EXC = 32'd1;
`else
  localparam logic [31:0] EXP_EXC = 32'd0;
`endif

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*32-1:0]    req_op_a, req_op_b;
  logic [NUM_REQ-1:0]       resp_valid;
  logic [31:0]              resp_data;
  State_e                   resp_state;
  logic                     busy;
  logic [31:0]              fpu_op_a, fpu_op_b, fpu_data;
  logic                     fpu_calc;
  State_e                   fpu_state;
  logic [CNT_W-1:0]         exc_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fpu_req_arbiter #(
    .NUM_REQ (NUM_REQ),
    .CNT_W   (CNT_W)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .req_valid_i  (req_valid),
    .req_ready_o  (req_ready),
    .req_op_a_i   (req_op_a),
    .req_op_b_i   (req_op_b),
    .resp_valid_o (resp_valid),
    .resp_data_o  (resp_data),
    .resp_state_o (resp_state),
    .busy_o       (busy),
    .fpu_op_a_o   (fpu_op_a),
    .fpu_op_b_o   (fpu_op_b),
    .fpu_calc_o   (fpu_calc),
    .fpu_data_i   (fpu_data),
    .fpu_state_i  (fpu_state),
    .exc_count_o  (exc_count)
  );

  // Minimal FPU: result registered on calc, held afterwards, shares the reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fpu_data  <= '0;
      fpu_state <= EXACT;
    end else if (fpu_calc) begin
      if (fpu_op_a == ONE && fpu_op_b == ONE) begin
        fpu_data  <= TWO;
        fpu_state <= EXACT;
      end else if (fpu_op_a == MAXE && fpu_op_b == MAXE) begin
        fpu_data  <= MAXE;
        fpu_state <= OVERFLOW;
      end else begin
        fpu_data  <= fpu_op_a + fpu_op_b;
        fpu_state <= INEXACT;
      end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b);
    req_op_a[id*32 +: 32] = a;
    req_op_b[id*32 +: 32] = b;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  // Starts in an IDLE cycle with valids applied; ends in the cycle carrying the response.
  task automatic serve(input string tag, input int id);
    #1;
    check_eq({tag, " ready"}, 32'(req_ready), 32'(1) << id);
    tick();
    check_eq({tag, " calc"}, 32'(fpu_calc), 32'd1);
    tick();
    tick();
    check_eq({tag, " resp_valid"}, 32'(resp_valid), 32'(1) << id);
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_op_a  = '0;
    req_op_b  = '0;

    // Reset values
    tick();
    tick();
    check_eq("rst resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst resp_data", resp_data, 32'd0);
    check_eq("rst resp_state", 32'(resp_state), 32'(EXACT));
    check_eq("rst calc", 32'(fpu_calc), 32'd0);
    check_eq("rst op_a", fpu_op_a, 32'd0);
    check_eq("rst busy", 32'(busy), 32'd0);
    check_eq("rst exc", 32'(exc_count), 32'd0);
    rst_n = 1'b1;
    tick();
    check_eq("idle ready", 32'(req_ready), 32'd0);

    // 1: req0 1.0 + 1.0
    set_req(0, ONE, ONE);
    req_valid = 4'b0001;
    #1;
    check_eq("t1 ready", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    check_eq("t1 calc", 32'(fpu_calc), 32'd1);
    check_eq("t1 busy issue", 32'(busy), 32'd1);
    check_eq("t1 op_a", fpu_op_a, ONE);
    check_eq("t1 ready issue", 32'(req_ready), 32'd0);
    tick();
    check_eq("t1 calc wait", 32'(fpu_calc), 32'd0);
    check_eq("t1 resp early", 32'(resp_valid), 32'd0);
    tick();
    check_eq("t1 resp_valid", 32'(resp_valid), 32'b0001);
    check_eq("t1 resp_data", resp_data, TWO);
    check_eq("t1 resp_state", 32'(resp_state), 32'(EXACT));
    check_eq("t1 busy idle", 32'(busy), 32'd0);
    check_eq("t1 op_a held", fpu_op_a, ONE);
    tick();
    check_eq("t1 pulse end", 32'(resp_valid), 32'd0);

    // 2: all valid, strict rotation
    do_reset();
    for (int i = 0; i < 4; i++) set_req(i, ONE, ONE);
    req_valid = 4'b1111;
    serve("t2 g0", 0);
    serve("t2 g1", 1);
    serve("t2 g2", 2);
    serve("t2 g3", 3);
    serve("t2 g0b", 0);
    req_valid = '0;

    // 3: req0 and req2 held, alternate
    do_reset();
    req_valid = 4'b0101;
    serve("t3 g0", 0);
    serve("t3 g2", 2);
    serve("t3 g0b", 0);
    serve("t3 g2b", 2);
    req_valid = '0;

    // 4: overflow from req1
    do_reset();
    set_req(1, MAXE, MAXE);
    req_valid = 4'b0010;
    serve("t4", 1);
    check_eq("t4 data", resp_data, MAXE);
    check_eq("t4 state", 32'(resp_state), 32'(OVERFLOW));
    check_eq("t4 exc", 32'(exc_count), EXP_EXC);
    req_valid = '0;

    // 5: reset during ISSUE aborts the op
    do_reset();
    set_req(0, ONE, ONE);
    set_req(3, TWO, ONE);
    req_valid = 4'b0001;
    #1;
    tick();
    check_eq("t5 in issue", 32'(fpu_calc), 32'd1);
    rst_n     = 1'b0;
    req_valid = '0;
    tick();
    check_eq("t5 rst busy", 32'(busy), 32'd0);
    check_eq("t5 rst calc", 32'(fpu_calc), 32'd0);
    check_eq("t5 rst op_a", fpu_op_a, 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check_eq("t5 no resp", 32'(resp_valid), 32'd0);
      tick();
    end
    req_valid = 4'b1001;
    serve("t5 g0", 0);
    serve("t5 g3", 3);
    check_eq("t5 g3 data", resp_data, 32'h7E00_0000);
    check_eq("t5 g3 state", 32'(resp_state), 32'(INEXACT));
    req_valid = '0;

    // 6: req2 re-asserts in its response cycle
    do_reset();
    set_req(2, ONE, ONE);
    req_valid = 4'b0100;
    #1;
    check_eq("t6 ready1", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    tick();
    tick();
    check_eq("t6 resp1", 32'(resp_valid), 32'b0100);
    set_req(2, TWO, ONE);
    req_valid = 4'b0100;
    #1;
    check_eq("t6 ready2", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    check_eq("t6 calc2", 32'(fpu_calc), 32'd1);
    tick();
    check_eq("t6 gap", 32'(resp_valid), 32'd0);
    tick();
    check_eq("t6 resp2", 32'(resp_valid), 32'b0100);
    check_eq("t6 data2", resp_data, 32'h7E00_0000);
    check_eq("t6 state2", 32'(resp_state), 32'(INEXACT));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
